// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : 32-bit SPI responder. Synchronises sclk/ss/mosi into PCLK,
//               supports all CPOL/CPHA modes and MSB/LSB-first order.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        sclk,
    input  logic        ss,
    input  logic        mosi,
    output logic        miso,
    input  logic [7:0]  SPICR_1,
    input  logic [31:0] SWDATA,
    input  logic        SWLOAD,
    input  logic [7:0]  SPISR_CLR,
    output logic [31:0] SRDATA,
    output logic        rx_valid,
    output logic [7:0]  SPISR
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync, r_sync_vld;
    logic        r_sclk_q, r_ss_q;
    logic [1:0]  r_state, w_state_nxt;
    logic [5:0]  r_bitcnt;
    logic [31:0] r_tx, r_rx, r_txbuf, r_srdata;
    logic        r_miso, r_rx_valid;
    logic        r_spif, r_ovrf, r_sptef, r_modf;

    logic w_spe, w_cpol, w_cpha, w_lsbfe;
    logic w_sclk_s, w_ss_s, w_mosi_s;
    logic w_edge, w_lead, w_trail, w_sample, w_shift;
    logic w_start, w_active, w_abort, w_last;
    logic [31:0] w_tx_word;
    logic w_unused;

    function automatic logic f_first(input logic [31:0] d, input logic lsb);
        return lsb ? d[0] : d[31];
    endfunction

    function automatic logic [31:0] f_adv(input logic [31:0] d, input logic lsb);
        return lsb ? {1'b0, d[31:1]} : {d[30:0], 1'b0};
    endfunction

    assign w_spe    = SPICR_1[6];
    assign w_cpol   = SPICR_1[3];
    assign w_cpha   = SPICR_1[2];
    assign w_lsbfe  = SPICR_1[0];
    assign w_unused = ^{SPICR_1[7], SPICR_1[5:4], SPICR_1[1], SPISR_CLR[5], SPISR_CLR[3:0]};

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    assign w_edge   = (w_sclk_s != r_sclk_q);
    assign w_lead   = w_edge && (w_sclk_s != w_cpol);
    assign w_trail  = w_edge && (w_sclk_s == w_cpol);
    assign w_sample = w_cpha ? w_trail : w_lead;
    assign w_shift  = w_cpha ? w_lead : w_trail;

    assign w_start  = (r_state == S_IDLE) && w_spe && r_ss_q && !w_ss_s;
    assign w_active = (r_state == S_SHIFT) && w_spe && !w_ss_s;
    assign w_abort  = (r_state == S_SHIFT) && w_spe && w_ss_s;
    assign w_last   = w_active && w_sample && (r_bitcnt == 6'd31);

    assign w_tx_word = r_sptef ? 32'h0 : r_txbuf;

    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_spe) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start) w_state_nxt = S_SHIFT;
                S_SHIFT: begin
                    if (w_abort)     w_state_nxt = S_IDLE;
                    else if (w_last) w_state_nxt = S_DONE;
                end
                S_DONE:  w_state_nxt = S_WAIT;
                default: if (w_ss_s) w_state_nxt = S_IDLE;
            endcase
        end
    end

    // r_sync_vld marks when the synchronisers hold real pin values, so the
    // reset value of ss cannot masquerade as a falling edge.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sync_vld  <= '0;
            r_sclk_q    <= 1'b0;
            r_ss_q      <= 1'b0;
            r_bitcnt    <= 6'd0;
            r_tx        <= 32'h0;
            r_rx        <= 32'h0;
            r_miso      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            r_sclk_q    <= w_sclk_s;
            r_ss_q      <= r_sync_vld[SYNC_STAGES-1] ? w_ss_s : 1'b0;

            if (w_start) begin
                r_bitcnt <= 6'd0;
                if (w_cpha) begin
                    r_tx   <= w_tx_word;
                    r_miso <= 1'b0;
                end else begin
                    r_tx   <= f_adv(w_tx_word, w_lsbfe);
                    r_miso <= f_first(w_tx_word, w_lsbfe);
                end
            end else if (w_active) begin
                if (w_shift) begin
                    r_miso <= f_first(r_tx, w_lsbfe);
                    r_tx   <= f_adv(r_tx, w_lsbfe);
                end
                if (w_sample) begin
                    r_rx     <= w_lsbfe ? {w_mosi_s, r_rx[31:1]} : {r_rx[30:0], w_mosi_s};
                    r_bitcnt <= r_bitcnt + 6'd1;
                end
            end else begin
                r_miso   <= 1'b0;
                r_bitcnt <= 6'd0;
            end
        end
    end

    // Status flags: a set event in the same cycle takes priority over a clear.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            r_txbuf    <= 32'h0;
            r_srdata   <= 32'h0;
            r_rx_valid <= 1'b0;
            r_spif     <= 1'b0;
            r_ovrf     <= 1'b0;
            r_sptef    <= 1'b1;
            r_modf     <= 1'b0;
        end else begin
            r_rx_valid <= (r_state == S_DONE);
            if (r_state == S_DONE) r_srdata <= r_rx;

            if (SWLOAD) begin
                r_txbuf <= SWDATA;
                r_sptef <= 1'b0;
            end else if (w_start) begin
                r_sptef <= 1'b1;
            end

            if (r_state == S_DONE)  r_spif <= 1'b1;
            else if (SPISR_CLR[7])  r_spif <= 1'b0;

            if ((r_state == S_DONE) && r_spif && !SPISR_CLR[7]) r_ovrf <= 1'b1;
            else if (SPISR_CLR[6])                              r_ovrf <= 1'b0;

            if (w_abort)           r_modf <= 1'b1;
            else if (SPISR_CLR[4]) r_modf <= 1'b0;
        end
    end

    assign miso     = r_miso;
    assign SRDATA   = r_srdata;
    assign rx_valid = r_rx_valid;
    assign SPISR    = {r_spif, r_ovrf, r_sptef, r_modf, 4'b0000};

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave
// Description : Self-checking bench for spi_slave with a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int H = 6;

    logic        PCLK = 1'b0;
    logic        PRESETn, sclk, ss, mosi, miso, SWLOAD, rx_valid;
    logic [7:0]  SPICR_1, SPISR_CLR, SPISR;
    logic [31:0] SWDATA, SRDATA;

    int n_checks = 0;
    int n_errors = 0;
    int n_rxv    = 0;

    // Word-level reference state
    logic [31:0] m_buf, m_srdata;
    logic        m_sptef, m_spif, m_ovrf, m_modf;
    int          m_rxv;

    spi_slave #(.SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .SPICR_1(SPICR_1), .SWDATA(SWDATA), .SWLOAD(SWLOAD),
        .SPISR_CLR(SPISR_CLR), .SRDATA(SRDATA), .rx_valid(rx_valid), .SPISR(SPISR)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) if (rx_valid) n_rxv++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_spisr();
        return {m_spif, m_ovrf, m_sptef, m_modf, 4'b0000};
    endfunction

    task automatic model_reset();
        m_buf = 0; m_srdata = 0; m_sptef = 1; m_spif = 0; m_ovrf = 0; m_modf = 0;
    endtask

    task automatic load(input logic [31:0] w);
        @(negedge PCLK); SWDATA = w; SWLOAD = 1'b1;
        @(negedge PCLK); SWLOAD = 1'b0;
        m_buf = w; m_sptef = 1'b0;
    endtask

    task automatic clr(input logic [7:0] mask);
        @(negedge PCLK); SPISR_CLR = mask;
        @(negedge PCLK); SPISR_CLR = 8'h00;
        if (mask[7]) m_spif = 1'b0;
        if (mask[6]) m_ovrf = 1'b0;
        if (mask[4]) m_modf = 1'b0;
    endtask

    // Acts as the SPI master; captures miso at the master's sample edges.
    task automatic run_frame(input logic cpol, input logic cpha, input logic lsbfe,
                             input logic [31:0] mosi_w, input int nbits, input bit raise,
                             output logic [31:0] miso_w);
        int pos;
        miso_w  = 32'h0;
        SPICR_1 = {1'b0, 1'b1, 2'b00, cpol, cpha, 1'b0, lsbfe};
        sclk    = cpol;
        repeat (H) @(negedge PCLK);
        ss = 1'b0;
        if (!cpha) mosi = mosi_w[lsbfe ? 0 : 31];
        repeat (H) @(negedge PCLK);
        for (int i = 0; i < nbits; i++) begin
            pos = lsbfe ? i : 31 - i;
            if (cpha) mosi = mosi_w[pos];
            else      miso_w[pos] = miso;
            sclk = ~cpol;
            repeat (H) @(negedge PCLK);
            if (cpha)        miso_w[pos] = miso;
            else if (i < 31) mosi = mosi_w[lsbfe ? i + 1 : 30 - i];
            sclk = cpol;
            repeat (H) @(negedge PCLK);
        end
        if (raise) begin
            ss = 1'b1;
            repeat (8) @(negedge PCLK);
        end
    endtask

    task automatic frame(input logic cpol, input logic cpha, input logic lsbfe,
                         input logic [31:0] rxw, input int nbits, input string tag);
        logic [31:0] exp_tx, got_tx;
        exp_tx  = m_sptef ? 32'h0 : m_buf;
        m_sptef = 1'b1;
        run_frame(cpol, cpha, lsbfe, rxw, nbits, 1'b1, got_tx);
        if (nbits == 32) begin
            if (m_spif) m_ovrf = 1'b1;
            m_spif   = 1'b1;
            m_srdata = rxw;
            m_rxv++;
            check({tag, " miso"}, got_tx, exp_tx);
        end else begin
            m_modf = 1'b1;
        end
        check({tag, " srdata"}, SRDATA, m_srdata);
        check({tag, " rxv"}, n_rxv, m_rxv);
        check({tag, " spisr"}, {24'h0, SPISR}, {24'h0, m_spisr()});
    endtask

    initial begin
        logic [31:0] w, dummy;
        logic [7:0]  masks [4];
        masks = '{8'h00, 8'h80, 8'hC0, 8'hD0};
        PRESETn = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
        SWLOAD = 1'b0; SWDATA = 32'h0; SPISR_CLR = 8'h0; SPICR_1 = 8'h0;
        m_rxv = 0;
        model_reset();
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b0;
        repeat (3) @(negedge PCLK);
        check("rst miso", {31'h0, miso}, 32'h0);
        check("rst srdata", SRDATA, 32'h0);
        check("rst rxv", {31'h0, rx_valid}, 32'h0);
        check("rst spisr", {24'h0, SPISR}, 32'h20);

        load(32'hA5C3_0F81);
        frame(1'b0, 1'b0, 1'b0, 32'h1234_5678, 32, "mode0");
        check("mode0 spisr", {24'h0, SPISR}, 32'hA0);
        clr(8'h80);

        for (int m = 1; m < 4; m++) begin
            load(32'h0000_0001);
            frame(m[1], m[0], 1'b1, 32'h8000_0000, 32, "lsb");
            clr(8'h80);
        end

        frame(1'b0, 1'b0, 1'b0, $urandom, 32, "noload");
        clr(8'hD0);

        load($urandom);
        frame(1'b0, 1'b1, 1'b0, $urandom, 32, "ovr1");
        load($urandom);
        frame(1'b1, 1'b0, 1'b1, $urandom, 32, "ovr2");
        check("ovr spisr", {24'h0, SPISR}, 32'hE0);
        clr(8'hC0);
        check("ovr clr", {24'h0, SPISR}, 32'h20);

        load($urandom);
        frame(1'b0, 1'b0, 1'b0, $urandom, 13, "abort");
        load($urandom);
        frame(1'b1, 1'b1, 1'b0, $urandom, 32, "after_abort");
        clr(8'hD0);

        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) load($urandom);
            w = $urandom;
            frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), w, 32, "rand");
            clr(masks[$urandom_range(0, 3)]);
            check("rand clr", {24'h0, SPISR}, {24'h0, m_spisr()});
        end

        load(32'hFFFF_FFFF);
        run_frame(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 10, 1'b0, dummy);
        PRESETn = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b0;
        model_reset();
        check("mid miso", {31'h0, miso}, 32'h0);
        check("mid srdata", SRDATA, 32'h0);
        check("mid rxv", {31'h0, rx_valid}, 32'h0);
        check("mid spisr", {24'h0, SPISR}, 32'h20);
        for (int i = 0; i < 34; i++) begin
            sclk = ~sclk;
            repeat (H) @(negedge PCLK);
            sclk = ~sclk;
            repeat (H) @(negedge PCLK);
        end
        ss = 1'b1;
        repeat (8) @(negedge PCLK);
        check("post rst rxv", n_rxv, m_rxv);
        check("post rst spisr", {24'h0, SPISR}, {24'h0, m_spisr()});
        check("post rst srdata", SRDATA, m_srdata);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
# spi_slave

SPI responder that pairs with the team's 32-bit SPI master on the same PCLK-based peripheral fabric. It samples the externally driven sclk/ss/mosi into the PCLK domain and shifts one 32-bit frame per ss assertion. It supports all four CPOL/CPHA modes and MSB- or LSB-first order. It returns the received word with a valid pulse and status flags, and it drives miso from a software-loaded transmit buffer.

## Interface
- SYNC_STAGES, 2: synchronizer depth for the sclk, ss and mosi inputs (minimum 2).
- PCLK  in  1  sole clock; all state updates on its rising edge.
- PRESETn  in  1  reset, synchronous, active-high (1 = reset).
- sclk  in  1  serial clock from the master, asynchronous to PCLK.
- ss  in  1  slave select, active low.
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master; never tristated.
- SPICR_1  in  8  configuration: 6 SPE (enable), 3 CPOL, 2 CPHA, 0 LSBFE; all other bits ignored.
- SWDATA  in  32  word to transmit.
- SWLOAD  in  1  one-cycle pulse; captures SWDATA into the tx buffer.
- SPISR_CLR  in  8  write-one-to-clear strobe for SPISR bits 7, 6 and 4.
- SRDATA  out  32  last complete received word.
- rx_valid  out  1  one-cycle pulse when SRDATA updates.
- SPISR  out  8  status: 7 SPIF (rx complete), 6 OVRF (overrun), 5 SPTEF (tx buffer empty), 4 MODF (frame aborted); other bits 0.

## Operation
- Synchronizers: sclk_s, ss_s and mosi_s are the SYNC_STAGES-flop outputs. A further flop sclk_q gives edge detect: edge = sclk_s != sclk_q.
- Leading edge = sclk_s transition away from CPOL. Trailing edge = transition back to CPOL.
- Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge is the other edge.
- Bit order: LSBFE=0 sends and receives bit 31 first, down to bit 0. LSBFE=1 sends and receives bit 0 first, up to bit 31.
- Tx buffer: SWLOAD loads the buffer and clears SPTEF. At frame start the buffer moves to the tx shift register and SPTEF is set. If SPTEF=1 at frame start, the frame transmits 32'h0. If SWLOAD coincides with frame start, the old buffer contents (or zero) are sent, the new word stays buffered, and SPTEF=0.
- State machine:
  - IDLE: miso=0, bitcnt=0. If SPE=1 and ss_s falls (1→0): load tx shift and go to SHIFT.
  - SHIFT: miso drives the current tx bit.
    - CPHA=0: bit 0 of the frame order is driven on entry. Each shift edge advances miso, except the trailing edge after bit 32.
    - CPHA=1: each leading edge advances miso to the next bit. The first leading edge drives the first bit.
    - Each sample edge shifts mosi_s into rx shift and increments bitcnt (6-bit). Go to DONE after the 32nd sample.
  - DONE (1 cycle):
    - SRDATA <= assembled word; rx_valid=1.
    - If SPIF was already 1 and is not being cleared this cycle, set OVRF.
    - Set SPIF, then go to WAIT.
  - WAIT: sclk edges are ignored and miso=0. Return to IDLE when ss_s=1.
- ss_s rises during SHIFT: abort the frame. Set MODF, leave SRDATA unchanged, no rx_valid, go to IDLE. The tx shift contents are discarded and SPTEF is not restored.
- SPE=0 in any state: go to IDLE on the next cycle. SPISR and SRDATA are kept.
- SPISR_CLR: bits 7, 6 and 4 clear when strobed. A set event in the same cycle wins over the clear.

## Timing
- Reset values: miso=0, SRDATA=0, rx_valid=0, SPISR=8'h20, state IDLE, tx buffer=0. Synchronizer flops reset to sclk=CPOL-independent 0, ss=1, mosi=0.
- Reset mid-frame: returns to IDLE next cycle. Status returns to reset values.
- Input constraint: sclk high and low phases are each at least 4 PCLK. ss setup before the first sclk edge and hold after the last edge are each at least 4 PCLK.
- Latency: a pin transition first sampled at cycle t produces its detected-edge action at register outputs at t+SYNC_STAGES+1.
  - ss fall → first miso bit (CPHA=0): 3 PCLK with SYNC_STAGES=2.
  - Final sample edge action → rx_valid/SRDATA: +1 PCLK, via DONE.
- miso changes only on a shift-edge action or on entry to SHIFT. It is stable across the master's sample edge under the input constraint.

## Test plan
- Mode 0, LSBFE=0, SWLOAD 32'hA5C3_0F81; master sends 32'h1234_5678 → miso streams A5C30F81 MSB first; rx_valid pulses once; SRDATA=32'h12345678; SPISR=8'h80 plus SPTEF=1 (8'hA0).
- Modes 1, 2 and 3, each with LSBFE=1, TX 32'h0000_0001, RX 32'h8000_0000 → first miso bit 1, SRDATA=32'h80000000, in all three modes.
- No SWLOAD before frame → miso all zero; SPTEF stays 1; the received word is still captured correctly.
- Two frames without SPISR_CLR → second rx_valid sets OVRF (SPISR=8'hE0). Then strobe SPISR_CLR=8'hC0 → SPISR=8'h20.
- ss deasserted after 13 bits → MODF=1, no rx_valid, SRDATA keeps its prior value. The next full frame is received correctly.
- PRESETn=1 for one cycle mid-frame → all outputs return to reset values next cycle. Toggling sclk with ss low afterward (no new ss fall) produces no rx_valid.
